alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one external 4-bit ALU between two requesters. Each requester issues ops over a
//   valid/ready port and gets results back through its own 1-entry response buffer.
//   The block arbitrates, registers the winning operands onto the ALU and captures
//   result and flags. It sits between the two client blocks and the ALU instance.
// PARAMETERS
//   WIDTH   4   operand/result width; must match the ALU
//   RR_EN   1   1 = round-robin between requesters; 0 = fixed priority, requester 0 wins
// PORTS
//   clk           in   1      clock; all state updates on rising edge
//   rst           in   1      asynchronous reset, active-high
//   req0_valid    in   1      requester 0 has an op
//   req0_ready    out  1      requester 0 op accepted this cycle (when valid)
//   req0_op       in   3      ALU function select (000 add ... 111 equal)
//   req0_a        in   WIDTH  operand A
//   req0_b        in   WIDTH  operand B
//   req1_*        -    -      same five signals for requester 1
//   rsp0_valid    out  1      response buffer 0 holds a result
//   rsp0_ready    in   1      requester 0 consumes the response
//   rsp0_res      out  WIDTH  captured alu_res
//   rsp0_flags    out  3      captured {alu_carry, alu_overflow, alu_zero}
//   rsp1_*        -    -      same four signals for requester 1
//   alu_fnselec   out  3      registered op to ALU
//   alu_a         out  WIDTH  registered operand A to ALU
//   alu_b         out  WIDTH  registered operand B to ALU
//   alu_res       in   WIDTH  ALU result (combinational from alu_* outputs)
//   alu_zero / alu_overflow / alu_carry   in 1 each   ALU flags
//   busy          out  1      1 while state = EXEC
// BEHAVIOUR
//   Reset: state=IDLE, alu_fnselec/alu_a/alu_b=0, rspN_valid=0, rspN_res=0, rspN_flags=0,
//     last_grant=1 (requester 0 wins the first tie), busy=0. An in-flight op is dropped.
//   FSM: IDLE -> EXEC on accept; EXEC -> IDLE unconditionally after one cycle.
//   Eligibility: eligN = reqN_valid & ~rspN_valid. Only eligible requesters are granted.
//   Grant (IDLE only): one eligible -> that one. Both eligible -> RR_EN=1: the one that
//     is not last_grant; RR_EN=0: requester 0.
//   reqN_ready = (state==IDLE) & grant==N & eligN; combinational, at most one high per cycle.
//   Ready is 0 in EXEC. Accept = valid & ready.
//   Accept edge: latch op/a/b onto alu_fnselec/alu_a/alu_b. Record owner. last_grant<=N.
//     ALU outputs hold their last values while IDLE.
//   EXEC edge: rsp[owner]_res<=alu_res, rsp[owner]_flags<={carry,overflow,zero},
//     rsp[owner]_valid<=1.
//   Latency: accept at edge k -> rspN_valid high after edge k+1. Throughput: 1 op per 2 cycles.
//   Response: rspN_valid & rspN_ready clears valid at the edge. Data is stable while
//     valid & ~ready.
//   Fill and drain of the same buffer on one edge cannot occur: grant requires an empty buffer.
//     The other buffer drains independently.
//   Requester with a full buffer is skipped. The other requester is still served, with
//     no deadlock.
//   Inputs are sampled only at accept; op/a/b changes while not ready are ignored.
// TESTING (bench uses a behavioural ALU model)
//   Reset with all valids low -> all outputs 0, busy=0, both req_ready=0.
//   req0 op=000 a=7 b=9 at edge 0 -> alu_a=7 alu_b=9 after edge 0. Then rsp0_valid=1,
//     res=0, flags=3'b101 after edge 1.
//   Both valid continuously, rsp ready=1, RR_EN=1 -> grants 0,1,0,1; one accept every 2 cycles.
//   rsp1 full, rsp1_ready=0, both valid -> req1_ready stays 0 and req0 is served each slot.
//     Raise rsp1_ready -> req1 is granted next IDLE.
//   Assert rst during EXEC -> no rsp asserted, IDLE, outputs 0. First post-reset tie goes to req0.
//   RR_EN=0, both valid continuously -> req0 always granted; req1 is granted only once req0
//     is blocked by a full rsp0 buffer.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: picks a requester, registers its
// operands onto the ALU, and captures result and flags into that requester's response buffer.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_res,
  output logic [2:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_res,
  output logic [2:0]       rsp1_flags,
  output logic [2:0]       alu_fnselec,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       owner;
  logic       grant;
  logic       elig0, elig1;
  logic       accept;
  logic [2:0] alu_flags;

  // A requester whose response buffer is still full cannot be granted, which is what
  // keeps a fill and a drain of the same buffer from landing on one edge.
  assign elig0 = req0_valid & ~rsp0_valid;
  assign elig1 = req1_valid & ~rsp1_valid;

  always_comb begin
    // NOTE: grant gets a default first so every path assigns it and no latch is inferred.
    grant = 1'b0;
    if (elig0 && elig1) begin
      grant = RR_EN ? ~last_grant : 1'b0;
    end else if (elig1) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) & elig0 & ~grant;
  assign req1_ready = (state == IDLE) & elig1 &  grant;
  // Ready is only ever raised for a valid requester, so either ready implies an accept.
  assign accept     = req0_ready | req1_ready;
  assign busy       = (state == EXEC);
  assign alu_flags  = {alu_carry, alu_overflow, alu_zero};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      alu_fnselec <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner       <= grant;
        last_grant  <= grant;
        alu_fnselec <= grant ? req1_op : req0_op;
        alu_a       <= grant ? req1_a  : req0_a;
        alu_b       <= grant ? req1_b  : req0_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_res   <= '0;
      rsp0_flags <= '0;
    end else if (busy && !owner) begin
      rsp0_valid <= 1'b1;
      rsp0_res   <= alu_res;
      rsp0_flags <= alu_flags;
    end else if (rsp0_valid && rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid <= 1'b0;
      rsp1_res   <= '0;
      rsp1_flags <= '0;
    end else if (busy && owner) begin
      rsp1_valid <= 1'b1;
      rsp1_res   <= alu_res;
      rsp1_flags <= alu_flags;
    end else if (rsp1_valid && rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share one stimulus stream;
// directed tables and sequences plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         r_valid [2];
  logic [2:0]   r_op    [2];
  logic [W-1:0] r_a     [2];
  logic [W-1:0] r_b     [2];
  logic         s_ready [2];

  // [dut][requester]; dut 0 is round-robin, dut 1 fixed priority
  logic         rq_rdy [2][2];
  logic         rs_v   [2][2];
  logic [W-1:0] rs_res [2][2];
  logic [2:0]   rs_flg [2][2];
  logic [2:0]   a_op  [2];
  logic [W-1:0] a_a   [2];
  logic [W-1:0] a_b   [2];
  logic [W-1:0] a_res [2];
  logic         a_z [2], a_v [2], a_c [2];
  logic         bsy [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural ALU: returns {res, carry, overflow, zero}
  function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {r, c, v, (r == 4'd0)};
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    assign {a_res[d], a_c[d], a_v[d], a_z[d]} = alu_f(a_op[d], a_a[d], a_b[d]);

    alu_arbiter #(.WIDTH(W), .RR_EN(d == 0)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(r_valid[0]), .req0_ready(rq_rdy[d][0]), .req0_op(r_op[0]), .req0_a(r_a[0]), .req0_b(r_b[0]),
      .req1_valid(r_valid[1]), .req1_ready(rq_rdy[d][1]), .req1_op(r_op[1]), .req1_a(r_a[1]), .req1_b(r_b[1]),
      .rsp0_valid(rs_v[d][0]), .rsp0_ready(s_ready[0]), .rsp0_res(rs_res[d][0]), .rsp0_flags(rs_flg[d][0]),
      .rsp1_valid(rs_v[d][1]), .rsp1_ready(s_ready[1]), .rsp1_res(rs_res[d][1]), .rsp1_flags(rs_flg[d][1]),
      .alu_fnselec(a_op[d]), .alu_a(a_a[d]), .alu_b(a_b[d]),
      .alu_res(a_res[d]), .alu_zero(a_z[d]), .alu_overflow(a_v[d]), .alu_carry(a_c[d]),
      .busy(bsy[d])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: one op in flight, a buffer slot per requester.
  bit           m_exec  [2];
  bit           m_owner [2];
  bit           m_last  [2];
  bit           m_rv    [2][2];
  logic [W-1:0] m_res   [2][2];
  logic [2:0]   m_flg   [2][2];
  logic [2:0]   m_op [2];
  logic [W-1:0] m_a  [2];
  logic [W-1:0] m_b  [2];

  function automatic int m_grant(input int d);
    bit e0, e1;
    if (m_exec[d]) return -1;
    e0 = r_valid[0] && !m_rv[d][0];
    e1 = r_valid[1] && !m_rv[d][1];
    if (e0 && e1) return (d == 0) ? (m_last[d] ? 0 : 1) : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_exec[d] = 1'b0; m_owner[d] = 1'b0; m_last[d] = 1'b1;
      m_op[d] = '0; m_a[d] = '0; m_b[d] = '0;
      for (int n = 0; n < 2; n++) begin
        m_rv[d][n] = 1'b0; m_res[d][n] = '0; m_flg[d][n] = '0;
      end
    end
  endtask

  task automatic model_step();
    int         g;
    logic [6:0] r;
    for (int d = 0; d < 2; d++) begin
      g = m_grant(d);
      for (int n = 0; n < 2; n++)
        if (m_rv[d][n] && s_ready[n]) m_rv[d][n] = 1'b0;
      if (m_exec[d]) begin
        r = alu_f(m_op[d], m_a[d], m_b[d]);
        m_res[d][m_owner[d]] = r[6:3];
        m_flg[d][m_owner[d]] = r[2:0];
        m_rv[d][m_owner[d]]  = 1'b1;
        m_exec[d] = 1'b0;
      end else if (g >= 0) begin
        m_op[d] = r_op[g]; m_a[d] = r_a[g]; m_b[d] = r_b[g];
        m_owner[d] = g[0]; m_last[d] = g[0];
        m_exec[d] = 1'b1;
      end
    end
  endtask

  task automatic compare(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        check($sformatf("%s d%0d req%0d_ready", tag, d, n), rq_rdy[d][n], m_grant(d) == n);
        check($sformatf("%s d%0d rsp%0d_valid", tag, d, n), rs_v[d][n], m_rv[d][n]);
        check($sformatf("%s d%0d rsp%0d_res", tag, d, n), rs_res[d][n], m_res[d][n]);
        check($sformatf("%s d%0d rsp%0d_flags", tag, d, n), rs_flg[d][n], m_flg[d][n]);
      end
      check($sformatf("%s d%0d alu_fnselec", tag, d), a_op[d], m_op[d]);
      check($sformatf("%s d%0d alu_a", tag, d), a_a[d], m_a[d]);
      check($sformatf("%s d%0d alu_b", tag, d), a_b[d], m_b[d]);
      check($sformatf("%s d%0d busy", tag, d), bsy[d], m_exec[d]);
    end
  endtask

  task automatic clear_inputs();
    for (int n = 0; n < 2; n++) begin
      r_valid[n] = 1'b0; r_op[n] = '0; r_a[n] = '0; r_b[n] = '0; s_ready[n] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic v0, v1, sr0, sr1;
    logic e_rdy0, e_rdy1, e_busy, e_rv0, e_rv1;
  } vec_t;

  vec_t tbl [12];
  int   g_seq [$];
  int   g_cyc [$];
  int   fp_cnt;

  initial begin
    // {v0, v1, rsp0_ready, rsp1_ready} -> {rdy0, rdy1, busy, rsp0_valid, rsp1_valid}
    tbl[0]  = '{1,1,1,0, 1,0,0,0,0};
    tbl[1]  = '{1,1,1,0, 0,0,1,0,0};
    tbl[2]  = '{1,1,1,0, 0,1,0,1,0};
    tbl[3]  = '{1,1,1,0, 0,0,1,0,0};
    tbl[4]  = '{1,1,1,0, 1,0,0,0,1};
    tbl[5]  = '{1,1,1,0, 0,0,1,0,1};
    tbl[6]  = '{1,1,1,0, 0,0,0,1,1};
    tbl[7]  = '{1,1,1,1, 1,0,0,0,1};
    tbl[8]  = '{1,1,1,1, 0,0,1,0,0};
    tbl[9]  = '{1,1,1,1, 0,1,0,1,0};
    tbl[10] = '{1,1,1,1, 0,0,1,0,0};
    tbl[11] = '{1,1,1,1, 1,0,0,0,1};

    do_reset();
    #2 compare("reset");

    // Single add: 7 + 9 wraps to 0 with carry and zero set
    r_valid[0] = 1'b1; r_op[0] = 3'd0; r_a[0] = 4'd7; r_b[0] = 4'd9;
    #2 check("basic req0_ready", rq_rdy[0][0], 1'b1);
    @(posedge clk); #1;
    r_valid[0] = 1'b0; r_op[0] = 3'd5; r_a[0] = 4'd3;
    check("basic alu_a", a_a[0], 4'd7);
    check("basic alu_b", a_b[0], 4'd9);
    check("basic alu_fnselec", a_op[0], 3'd0);
    check("basic busy", bsy[0], 1'b1);
    @(posedge clk); #1;
    check("basic rsp0_valid", rs_v[0][0], 1'b1);
    check("basic rsp0_res", rs_res[0][0], 4'd0);
    check("basic rsp0_flags", rs_flg[0][0], 3'b101);
    check("basic busy after exec", bsy[0], 1'b0);
    @(posedge clk); #1;
    check("hold rsp0_valid", rs_v[0][0], 1'b1);
    check("hold rsp0_flags", rs_flg[0][0], 3'b101);
    check("hold alu_a", a_a[0], 4'd7);
    s_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("drain rsp0_valid", rs_v[0][0], 1'b0);

    // Full rsp1 buffer skips requester 1 until it drains
    do_reset();
    for (int n = 0; n < 2; n++) begin
      r_op[n] = 3'd2; r_a[n] = 4'hC; r_b[n] = 4'h6;
    end
    for (int i = 0; i < 12; i++) begin
      r_valid[0] = tbl[i].v0;  r_valid[1] = tbl[i].v1;
      s_ready[0] = tbl[i].sr0; s_ready[1] = tbl[i].sr1;
      #2;
      check($sformatf("tbl%0d req0_ready", i), rq_rdy[0][0], tbl[i].e_rdy0);
      check($sformatf("tbl%0d req1_ready", i), rq_rdy[0][1], tbl[i].e_rdy1);
      check($sformatf("tbl%0d busy", i), bsy[0], tbl[i].e_busy);
      check($sformatf("tbl%0d rsp0_valid", i), rs_v[0][0], tbl[i].e_rv0);
      check($sformatf("tbl%0d rsp1_valid", i), rs_v[0][1], tbl[i].e_rv1);
      @(posedge clk); #1;
    end

    // Both valid, both drained every cycle: alternation on 2-cycle slots
    do_reset();
    fp_cnt = 0;
    r_valid[0] = 1'b1; r_valid[1] = 1'b1; s_ready[0] = 1'b1; s_ready[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (rq_rdy[0][0]) begin g_seq.push_back(0); g_cyc.push_back(c); end
      if (rq_rdy[0][1]) begin g_seq.push_back(1); g_cyc.push_back(c); end
      if (rq_rdy[1][1]) begin
        fp_cnt++;
        check($sformatf("fixed prio req1 only when rsp0 full c%0d", c), rs_v[1][0], 1'b1);
      end
      @(posedge clk); #1;
    end
    check("rr accept count", g_seq.size(), 4);
    for (int i = 0; i < g_seq.size(); i++) begin
      check($sformatf("rr grant %0d", i), g_seq[i], i % 2);
      check($sformatf("rr accept cycle %0d", i), g_cyc[i], 2 * i);
    end
    check("fixed prio req1 grants", fp_cnt, 2);

    // Reset in the middle of an op drops it
    do_reset();
    r_valid[0] = 1'b1; r_valid[1] = 1'b1; r_op[1] = 3'd4; r_a[1] = 4'h5; r_b[1] = 4'hA;
    #2;
    check("tie goes to req0", rq_rdy[0][0], 1'b1);
    check("tie req1 waits", rq_rdy[0][1], 1'b0);
    @(posedge clk); #1;
    check("mid busy", bsy[0], 1'b1);
    rst = 1'b1;
    #1;
    check("rst busy", bsy[0], 1'b0);
    check("rst alu_a", a_a[0], 4'd0);
    check("rst alu_fnselec", a_op[0], 3'd0);
    @(posedge clk); #1;
    check("rst rsp0_valid", rs_v[0][0], 1'b0);
    check("rst rsp1_valid", rs_v[0][1], 1'b0);
    rst = 1'b0;
    #1;
    check("post-rst tie req0", rq_rdy[0][0], 1'b1);
    check("post-rst tie req1", rq_rdy[0][1], 1'b0);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        r_valid[n] = ($urandom_range(0, 3) != 0);
        s_ready[n] = ($urandom_range(0, 9) < 6);
        r_op[n]    = 3'($urandom_range(0, 7));
        r_a[n]     = 4'($urandom_range(0, 15));
        r_b[n]     = 4'($urandom_range(0, 15));
      end
      #2 compare($sformatf("rand c%0d", c));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
